// File: rtl/alu_arbiter_pkg.sv
// Shared types for the ALU arbiter: ALU opcodes, arbiter FSM states and
// the requester count. Opcode encodings 10..15 are deliberately unassigned;
// the ALU flags them as invalid.
package alu_arbiter_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLTS = 4'd8,
        ALU_SLTU = 4'd9
    } alu_opcode_e;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_EXEC = 2'd1,
        ARB_RESP = 2'd2
    } alu_arb_state_e;

    localparam int ALU_ARB_NUM_REQ = 2;

    // Requester index to one-hot request/response vector.
    function automatic logic [ALU_ARB_NUM_REQ-1:0] req_onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/alu_arbiter_rr_arbiter_2.sv
// Two-way round-robin arbiter. The pick is purely combinational from the
// valid vector and the remembered last winner; the last winner only moves
// when the caller reports that a grant was actually taken (update_i).
// Kept generic so other shared units can reuse it.
module rr_arbiter_2
    import alu_arbiter_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic [ALU_ARB_NUM_REQ-1:0] valid_i,
    input  logic                       update_i,
    output logic [ALU_ARB_NUM_REQ-1:0] grant_o,
    output logic                       grant_idx_o
);

    logic last_grant_q;
    logic last_grant_d;

    // Pick a winner: single valid wins outright, a conflict goes to the
    // requester that did not win last time.
    always_comb begin
        // NOTE: every combinationally written signal gets a default first so
        // no path through the block leaves it unassigned (no latch).
        grant_idx_o  = 1'b0;
        grant_o      = '0;
        last_grant_d = last_grant_q;

        if (valid_i == 2'b11) begin
            grant_idx_o = ~last_grant_q;
        end else begin
            grant_idx_o = valid_i[1];
        end

        if (|valid_i) begin
            grant_o = req_onehot(grant_idx_o);
        end

        if (update_i) begin
            last_grant_d = grant_idx_o;
        end
    end

    // Last-winner register; resets to requester 1 so requester 0 takes the
    // first conflict.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (reset) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two requesters. Each transaction is
// accept (IDLE) -> execute (EXEC, ALU enabled from latched operands) ->
// respond (RESP, result held until the owner takes it).
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic                       clk,
    input  logic                       reset,

    input  logic [ALU_ARB_NUM_REQ-1:0] req_valid_ip,
    output logic [ALU_ARB_NUM_REQ-1:0] req_ready_op,
    input  alu_opcode_e                req0_operator_ip,
    input  logic [DATA_W-1:0]          req0_operand_a_ip,
    input  logic [DATA_W-1:0]          req0_operand_b_ip,
    input  alu_opcode_e                req1_operator_ip,
    input  logic [DATA_W-1:0]          req1_operand_a_ip,
    input  logic [DATA_W-1:0]          req1_operand_b_ip,

    output logic [ALU_ARB_NUM_REQ-1:0] resp_valid_op,
    input  logic [ALU_ARB_NUM_REQ-1:0] resp_ready_ip,
    output logic [DATA_W-1:0]          resp_result_op,
    output logic                       resp_error_op,

    output logic                       alu_enable_op,
    output alu_opcode_e                alu_operator_op,
    output logic [DATA_W-1:0]          alu_operand_a_op,
    output logic [DATA_W-1:0]          alu_operand_b_op,
    input  logic [DATA_W-1:0]          alu_result_ip,
    input  logic                       alu_valid_ip
);

    alu_arb_state_e    state_q, state_d;
    logic              owner_q, owner_d;
    alu_opcode_e       operator_q, operator_d;
    logic [DATA_W-1:0] operand_a_q, operand_a_d;
    logic [DATA_W-1:0] operand_b_q, operand_b_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              error_q, error_d;

    logic [ALU_ARB_NUM_REQ-1:0] arb_valid;
    logic [ALU_ARB_NUM_REQ-1:0] arb_grant;
    logic                       arb_grant_idx;
    logic                       handshake;

    // Arbitration is only offered in IDLE and never while reset is asserted,
    // so a pending request cannot be accepted mid-transaction.
    always_comb begin
        arb_valid = '0;
        if (state_q == ARB_IDLE && !reset) begin
            arb_valid = req_valid_ip;
        end
    end

    rr_arbiter_2 u_rr_arbiter (
        .clk         (clk),
        .reset       (reset),
        .valid_i     (arb_valid),
        .update_i    (handshake),
        .grant_o     (arb_grant),
        .grant_idx_o (arb_grant_idx)
    );

    // Handshake/ready and response/ALU outputs decoded from state.
    always_comb begin
        req_ready_op     = arb_grant;
        handshake        = |(req_valid_ip & arb_grant);
        resp_valid_op    = '0;
        resp_result_op   = result_q;
        resp_error_op    = error_q;
        alu_enable_op    = (state_q == ARB_EXEC);
        alu_operator_op  = operator_q;
        alu_operand_a_op = operand_a_q;
        alu_operand_b_op = operand_b_q;
        if (state_q == ARB_RESP) begin
            resp_valid_op = req_onehot(owner_q);
        end
    end

    // Next-state and register-load logic for the transaction FSM.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        operator_d  = operator_q;
        operand_a_d = operand_a_q;
        operand_b_d = operand_b_q;
        result_d    = result_q;
        error_d     = error_q;

        case (state_q)
            ARB_IDLE: begin
                if (handshake) begin
                    owner_d = arb_grant_idx;
                    if (arb_grant_idx) begin
                        operator_d  = req1_operator_ip;
                        operand_a_d = req1_operand_a_ip;
                        operand_b_d = req1_operand_b_ip;
                    end else begin
                        operator_d  = req0_operator_ip;
                        operand_a_d = req0_operand_a_ip;
                        operand_b_d = req0_operand_b_ip;
                    end
                    state_d = ARB_EXEC;
                end
            end
            ARB_EXEC: begin
                // An invalid operation returns a clean zero rather than
                // whatever the ALU left on its result port.
                error_d  = ~alu_valid_ip;
                result_d = alu_valid_ip ? alu_result_ip : '0;
                state_d  = ARB_RESP;
            end
            ARB_RESP: begin
                if (resp_ready_ip[owner_q]) begin
                    state_d = ARB_IDLE;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // State, operand and response registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the datapath registers are reset too because they drive
            // module outputs directly, which must read as zero/ALU_ADD after
            // reset rather than as stale operands.
            state_q     <= ARB_IDLE;
            owner_q     <= 1'b0;
            operator_q  <= ALU_ADD;
            operand_a_q <= '0;
            operand_b_q <= '0;
            result_q    <= '0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            operator_q  <= operator_d;
            operand_a_q <= operand_a_d;
            operand_b_q <= operand_b_d;
            result_q    <= result_d;
            error_q     <= error_d;
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter. A behavioural ALU sits on the ALU
// ports; expected grants come from a round-robin model kept as a plain
// "previous winner" integer, expected results from the ALU rules.
module tb_alu_arbiter;
    import alu_arbiter_pkg::*;

    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic [1:0]        req_valid_ip;
    logic [1:0]        req_ready_op;
    alu_opcode_e       req0_operator_ip, req1_operator_ip;
    logic [DATA_W-1:0] req0_operand_a_ip, req0_operand_b_ip;
    logic [DATA_W-1:0] req1_operand_a_ip, req1_operand_b_ip;
    logic [1:0]        resp_valid_op;
    logic [1:0]        resp_ready_ip;
    logic [DATA_W-1:0] resp_result_op;
    logic              resp_error_op;
    logic              alu_enable_op;
    alu_opcode_e       alu_operator_op;
    logic [DATA_W-1:0] alu_operand_a_op, alu_operand_b_op;
    logic [DATA_W-1:0] alu_result_ip;
    logic              alu_valid_ip;

    int n_tests = 0;
    int n_fail  = 0;
    int m_last  = 1;   // model: previous winner

    alu_opcode_e       req_op [2];
    logic [DATA_W-1:0] req_a  [2];
    logic [DATA_W-1:0] req_b  [2];

    always #5 clk = ~clk;

    alu_arbiter #(.DATA_W(DATA_W)) dut (
        .clk               (clk),
        .reset             (reset),
        .req_valid_ip      (req_valid_ip),
        .req_ready_op      (req_ready_op),
        .req0_operator_ip  (req0_operator_ip),
        .req0_operand_a_ip (req0_operand_a_ip),
        .req0_operand_b_ip (req0_operand_b_ip),
        .req1_operator_ip  (req1_operator_ip),
        .req1_operand_a_ip (req1_operand_a_ip),
        .req1_operand_b_ip (req1_operand_b_ip),
        .resp_valid_op     (resp_valid_op),
        .resp_ready_ip     (resp_ready_ip),
        .resp_result_op    (resp_result_op),
        .resp_error_op     (resp_error_op),
        .alu_enable_op     (alu_enable_op),
        .alu_operator_op   (alu_operator_op),
        .alu_operand_a_op  (alu_operand_a_op),
        .alu_operand_b_op  (alu_operand_b_op),
        .alu_result_ip     (alu_result_ip),
        .alu_valid_ip      (alu_valid_ip)
    );

    // {valid, result}; undefined opcodes return garbage with valid low.
    function automatic logic [32:0] alu_model(input alu_opcode_e op,
                                              input logic [31:0] a,
                                              input logic [31:0] b);
        case (op)
            ALU_ADD:  return {1'b1, a + b};
            ALU_SUB:  return {1'b1, a - b};
            ALU_AND:  return {1'b1, a & b};
            ALU_OR:   return {1'b1, a | b};
            ALU_XOR:  return {1'b1, a ^ b};
            ALU_SLL:  return {1'b1, a << b[4:0]};
            ALU_SRL:  return {1'b1, a >> b[4:0]};
            ALU_SRA:  return {1'b1, 32'($signed(a) >>> b[4:0])};
            ALU_SLTS: return {1'b1, 31'd0, $signed(a) < $signed(b)};
            ALU_SLTU: return {1'b1, 31'd0, a < b};
            default:  return {1'b0, 32'hDEAD_BEEF};
        endcase
    endfunction

    // Expected {error, result} seen by the requester.
    function automatic logic [32:0] expect_resp(input int idx);
        logic [32:0] r;
        r = alu_model(req_op[idx], req_a[idx], req_b[idx]);
        return r[32] ? {1'b0, r[31:0]} : {1'b1, 32'd0};
    endfunction

    function automatic int model_pick(input logic [1:0] v);
        if (v == 2'b11) return 1 - m_last;
        return v[1] ? 1 : 0;
    endfunction

    always_comb begin
        {alu_valid_ip, alu_result_ip} = alu_model(alu_operator_op, alu_operand_a_op, alu_operand_b_op);
    end

    task automatic apply_reqs(input logic [1:0] v);
        req0_operator_ip  = req_op[0];
        req0_operand_a_ip = req_a[0];
        req0_operand_b_ip = req_b[0];
        req1_operator_ip  = req_op[1];
        req1_operand_a_ip = req_a[1];
        req1_operand_b_ip = req_b[1];
        req_valid_ip      = v;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        req_valid_ip = 2'b00;
        resp_ready_ip = 2'b00;
        @(negedge clk);
        reset = 1'b0;
        m_last = 1;
        #1;
    endtask

    // Drives one full transaction (called in IDLE, a little after negedge)
    // and reports what was observed; callers compare against expectations.
    // seq_ok collects the cycle-by-cycle protocol observations.
    task automatic run_txn(input logic [1:0] v, input bit keep_valid,
                           output int gidx, output logic [31:0] res,
                           output logic err, output bit seq_ok);
        seq_ok = 1'b1;
        gidx   = -1;
        res    = '0;
        err    = 1'b0;
        apply_reqs(v);
        resp_ready_ip = 2'b00;
        #1;
        for (int c = 0; c < 20 && !(|(req_ready_op & req_valid_ip)); c++) begin
            @(negedge clk);
            #1;
        end
        if (!(|(req_ready_op & req_valid_ip))) begin
            req_valid_ip = 2'b00;
            seq_ok = 1'b0;
            return;
        end
        if (!$onehot(req_ready_op)) seq_ok = 1'b0;
        gidx = req_ready_op[1] ? 1 : 0;
        @(negedge clk);
        if (!keep_valid) req_valid_ip[gidx] = 1'b0;
        #1;
        if (alu_enable_op !== 1'b1 || req_ready_op !== 2'b00 || resp_valid_op !== 2'b00 ||
            alu_operator_op !== req_op[gidx] || alu_operand_a_op !== req_a[gidx] ||
            alu_operand_b_op !== req_b[gidx]) seq_ok = 1'b0;
        @(negedge clk);
        #1;
        if (alu_enable_op !== 1'b0 || req_ready_op !== 2'b00 ||
            resp_valid_op !== (gidx == 1 ? 2'b10 : 2'b01)) seq_ok = 1'b0;
        res = resp_result_op;
        err = resp_error_op;
        resp_ready_ip[gidx] = 1'b1;
        @(negedge clk);
        resp_ready_ip = 2'b00;
        #1;
        if (resp_valid_op !== 2'b00) seq_ok = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req_valid_ip = 2'b11;
        resp_ready_ip = 2'b00;
        req_op[0] = ALU_SUB; req_a[0] = 32'h1234; req_b[0] = 32'h10;
        req_op[1] = ALU_XOR; req_a[1] = 32'h55;   req_b[1] = 32'hAA;
        apply_reqs(2'b11);
        repeat (2) @(negedge clk);
        #1;
        n_tests++;
        if (req_ready_op !== 2'b00) begin
            $display("FAIL reset_ready: got %b want 00", req_ready_op);
            n_fail++;
        end
        n_tests++;
        if ({resp_valid_op, resp_error_op, resp_result_op, alu_enable_op,
             alu_operator_op, alu_operand_a_op, alu_operand_b_op} !== {2'b00, 1'b0, 32'd0, 1'b0, ALU_ADD, 32'd0, 32'd0}) begin
            $display("FAIL reset_outputs: valid=%b err=%b res=%h en=%b op=%0d a=%h b=%h want all zero/ADD",
                     resp_valid_op, resp_error_op, resp_result_op, alu_enable_op,
                     alu_operator_op, alu_operand_a_op, alu_operand_b_op);
            n_fail++;
        end
        reset = 1'b0;
        req_valid_ip = 2'b00;
        m_last = 1;
        @(negedge clk);
        #1;
    endtask

    task automatic test_single();
        int g; logic [31:0] r; logic e; bit ok;
        req_op[0] = ALU_ADD; req_a[0] = 32'd5; req_b[0] = 32'd7;
        run_txn(2'b01, 1'b0, g, r, e, ok);
        n_tests++;
        if (g !== 0 || r !== 32'd12 || e !== 1'b0 || !ok) begin
            $display("FAIL single_add: grant=%0d res=%0d err=%b seq=%b want 0/12/0/1", g, r, e, ok);
            n_fail++;
        end
        m_last = 0;
    endtask

    task automatic test_conflict_alternate();
        int g; logic [31:0] r; logic e; bit ok;
        int exp_g [6] = '{0, 1, 0, 1, 0, 1};
        pulse_reset();
        req_op[0] = ALU_SUB; req_a[0] = 32'd10; req_b[0] = 32'd3;
        req_op[1] = ALU_ADD; req_a[1] = 32'd1;  req_b[1] = 32'd1;
        for (int i = 0; i < 6; i++) begin
            run_txn(2'b11, 1'b1, g, r, e, ok);
            n_tests++;
            if (g !== exp_g[i] || r !== (exp_g[i] == 0 ? 32'd7 : 32'd2) || e !== 1'b0 || !ok) begin
                $display("FAIL conflict_%0d: grant=%0d res=%0d err=%b seq=%b want grant %0d", i, g, r, e, ok, exp_g[i]);
                n_fail++;
            end
            m_last = exp_g[i];
        end
        req_valid_ip = 2'b00;
    endtask

    task automatic test_signed_compare();
        int g; logic [31:0] r; logic e; bit ok;
        req_op[1] = ALU_SLTS; req_a[1] = 32'hFFFF_FFE0; req_b[1] = 32'd1;
        run_txn(2'b10, 1'b0, g, r, e, ok);
        n_tests++;
        if (g !== 1 || r !== 32'd1 || e !== 1'b0 || !ok) begin
            $display("FAIL slts_neg: grant=%0d res=%0d err=%b seq=%b want 1/1/0/1", g, r, e, ok);
            n_fail++;
        end
        req_a[1] = 32'd1; req_b[1] = 32'hFFFF_FFE0;
        run_txn(2'b10, 1'b0, g, r, e, ok);
        n_tests++;
        if (g !== 1 || r !== 32'd0 || e !== 1'b0 || !ok) begin
            $display("FAIL slts_swap: grant=%0d res=%0d err=%b seq=%b want 1/0/0/1", g, r, e, ok);
            n_fail++;
        end
        m_last = 1;
    endtask

    task automatic test_invalid_op();
        int g; logic [31:0] r; logic e; bit ok;
        req_op[0] = alu_opcode_e'(4'hF); req_a[0] = 32'd9; req_b[0] = 32'd9;
        run_txn(2'b01, 1'b0, g, r, e, ok);
        n_tests++;
        if (g !== 0 || r !== 32'd0 || e !== 1'b1 || !ok) begin
            $display("FAIL invalid_op: grant=%0d res=%h err=%b seq=%b want 0/0/1/1", g, r, e, ok);
            n_fail++;
        end
        m_last = 0;
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_r;
        req_op[0] = ALU_XOR; req_a[0] = $urandom; req_b[0] = $urandom;
        exp_r = req_a[0] ^ req_b[0];
        apply_reqs(2'b01);
        resp_ready_ip = 2'b00;
        #1;
        n_tests++;
        if (req_ready_op !== 2'b01) begin
            $display("FAIL bp_accept: ready=%b want 01", req_ready_op);
            n_fail++;
        end
        @(negedge clk);
        req_valid_ip = 2'b11;   // both keep requesting while the response waits
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            resp_ready_ip = (i % 2 == 1) ? 2'b10 : 2'b00;
            #1;
            n_tests++;
            if (resp_valid_op !== 2'b01 || resp_result_op !== exp_r || req_ready_op !== 2'b00) begin
                $display("FAIL bp_hold_%0d: valid=%b res=%h ready=%b want 01/%h/00",
                         i, resp_valid_op, resp_result_op, req_ready_op, exp_r);
                n_fail++;
            end
        end
        @(negedge clk);
        req_valid_ip = 2'b00;
        resp_ready_ip = 2'b01;
        @(negedge clk);
        resp_ready_ip = 2'b00;
        #1;
        n_tests++;
        if (resp_valid_op !== 2'b00) begin
            $display("FAIL bp_release: valid=%b want 00", resp_valid_op);
            n_fail++;
        end
        m_last = 0;
    endtask

    task automatic test_reset_mid(input bit in_resp);
        int g; logic [31:0] r; logic e; bit ok;
        bit seen_resp;
        req_op[0] = ALU_ADD; req_a[0] = 32'd5; req_b[0] = 32'd7;
        apply_reqs(2'b01);
        resp_ready_ip = 2'b00;
        @(negedge clk);           // handshake taken; now in EXEC
        req_valid_ip = 2'b00;
        if (in_resp) begin
            @(negedge clk);
            #1;
            n_tests++;
            if (resp_valid_op !== 2'b01 || resp_result_op !== 32'd12) begin
                $display("FAIL rst_resp_reach: valid=%b res=%0d want 01/12", resp_valid_op, resp_result_op);
                n_fail++;
            end
        end
        reset = 1'b1;
        req_valid_ip = 2'b11;
        #1;
        n_tests++;
        if (req_ready_op !== 2'b00) begin
            $display("FAIL rst_mid_ready_%0d: ready=%b want 00", in_resp, req_ready_op);
            n_fail++;
        end
        @(negedge clk);
        #1;
        n_tests++;
        if ({resp_valid_op, resp_error_op, resp_result_op, alu_enable_op,
             alu_operator_op, alu_operand_a_op, alu_operand_b_op} !== {2'b00, 1'b0, 32'd0, 1'b0, ALU_ADD, 32'd0, 32'd0}) begin
            $display("FAIL rst_mid_outputs_%0d: valid=%b res=%h en=%b a=%h want zeros",
                     in_resp, resp_valid_op, resp_result_op, alu_enable_op, alu_operand_a_op);
            n_fail++;
        end
        reset = 1'b0;
        req_valid_ip = 2'b00;
        m_last = 1;
        seen_resp = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            if (resp_valid_op !== 2'b00) seen_resp = 1'b1;
        end
        n_tests++;
        if (seen_resp) begin
            $display("FAIL rst_mid_noresp_%0d: response emitted for discarded transaction", in_resp);
            n_fail++;
        end
        req_op[1] = ALU_OR; req_a[1] = 32'hF0; req_b[1] = 32'h0F;
        run_txn(2'b11, 1'b0, g, r, e, ok);
        n_tests++;
        if (g !== 0 || r !== 32'd12 || !ok) begin
            $display("FAIL rst_mid_first_conflict_%0d: grant=%0d res=%0d seq=%b want 0/12/1", in_resp, g, r, ok);
            n_fail++;
        end
        m_last = 0;
        req_valid_ip = 2'b00;
    endtask

    task automatic test_random();
        int g; logic [31:0] r; logic e; bit ok;
        int exp_g; logic [32:0] exp_er;
        logic [1:0] v;
        for (int i = 0; i < 30; i++) begin
            v = 2'($urandom_range(1, 3));
            for (int k = 0; k < 2; k++) begin
                req_op[k] = alu_opcode_e'($urandom_range(0, 10));
                req_a[k]  = $urandom;
                req_b[k]  = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 40)) : $urandom;
            end
            exp_g  = model_pick(v);
            exp_er = expect_resp(exp_g);
            run_txn(v, 1'($urandom_range(0, 1)), g, r, e, ok);
            n_tests++;
            if (g !== exp_g || {e, r} !== exp_er || !ok) begin
                $display("FAIL random_%0d: v=%b grant=%0d err=%b res=%h seq=%b want grant %0d err=%b res=%h",
                         i, v, g, e, r, ok, exp_g, exp_er[32], exp_er[31:0]);
                n_fail++;
            end
            m_last = exp_g;
        end
        req_valid_ip = 2'b00;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_conflict_alternate();
        test_signed_compare();
        test_invalid_op();
        test_backpressure();
        test_reset_mid(1'b0);
        test_reset_mid(1'b1);
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
